// File: rtl/mips_mem_interface_pkg.sv
// Shared types and constants for the MIPS memory-interface stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mips_mem_interface_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        MI_IDLE = 2'd0,
        MI_BUSY = 2'd1,
        MI_DONE = 2'd2,
        MI_ERR  = 2'd3
    } memif_state_t;

    // Primary opcode field of a MIPS instruction word
    typedef logic [5:0] opcode_t;

    localparam int MEMIF_OPCODE_LSB = 26;

    localparam opcode_t RTYPE_OPCODE = 6'h00;
    localparam opcode_t BEQ_OPCODE   = 6'h04;
    localparam opcode_t LW_OPCODE    = 6'h23;
    localparam opcode_t SW_OPCODE    = 6'h2B;

    // Extract the opcode field from the low 32 bits of an instruction word
    function automatic opcode_t get_opcode(input logic [31:0] word);
        return word[MEMIF_OPCODE_LSB +: $bits(opcode_t)];
    endfunction

endpackage

// File: rtl/mips_mem_watchdog.sv
// Saturating cycle counter that flags a request held too long without ack.
// Latency: expired is combinational from the registered count.
// Backpressure: none; clr has priority over en, count never wraps.
module mips_mem_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    // expired is raised during the TIMEOUT-th counted cycle, so the owner
    // can leave the wait state at the edge that closes that cycle
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);
    localparam logic [W-1:0] SAT   = W'(TIMEOUT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear on request entry, otherwise count up and hold at SAT
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != SAT)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q >= LIMIT);

endmodule

// File: rtl/mips_mem_interface.sv
// Converts controller read/write/IR-write strobes into a registered req/ack memory access, holding IR and MDR.
// Latency: request registered one cycle after the strobe; data visible the cycle after ack (min 3-cycle access).
// Backpressure: stall holds the controller until the access completes; no ack within TIMEOUT cycles locks in err.
module mips_mem_interface
    import mips_mem_interface_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              ir_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] instr,
    output opcode_t           opcode,
    output logic [DATA_W-1:0] mdr,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    memif_state_t      state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              dst_ir_q, dst_ir_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              wd_clr;
    logic              wd_en;
    logic              wd_expired;

    assign wd_en = (state_q == MI_BUSY);

    mips_mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // Next-state and datapath register updates for the access sequencer
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        dst_ir_d = dst_ir_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        wd_clr   = 1'b0;
        case (state_q)
            MI_IDLE: begin
                if (cpu_rd && cpu_wr) begin
                    state_d = MI_ERR;
                end else if (cpu_rd || cpu_wr) begin
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    we_d     = cpu_wr;
                    // ir_write only steers reads; stores never touch IR
                    dst_ir_d = cpu_rd && ir_write;
                    req_d    = 1'b1;
                    wd_clr   = 1'b1;
                    state_d  = MI_BUSY;
                end
            end
            MI_BUSY: begin
                // An ack in the expiring cycle still completes the access
                if (mem_ack) begin
                    if (!we_q) begin
                        if (dst_ir_q) begin
                            ir_d = mem_rdata;
                        end else begin
                            mdr_d = mem_rdata;
                        end
                    end
                    req_d   = 1'b0;
                    state_d = MI_DONE;
                end else if (wd_expired) begin
                    req_d   = 1'b0;
                    state_d = MI_ERR;
                end
            end
            MI_DONE: begin
                state_d = MI_IDLE;
            end
            MI_ERR: begin
                req_d   = 1'b0;
                state_d = MI_ERR;
            end
            default: begin
                req_d   = 1'b0;
                state_d = MI_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MI_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            dst_ir_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ir_q     <= '0;
            mdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            dst_ir_q <= dst_ir_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
        end
    end

    // Stall covers the request cycle itself so the controller never advances before the access
    assign stall = ((state_q == MI_IDLE) && (cpu_rd || cpu_wr)) ||
                   (state_q == MI_BUSY) || (state_q == MI_ERR);

    assign err       = (state_q == MI_ERR);
    assign mem_req   = req_q;
    assign mem_we    = we_q && req_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign instr     = ir_q;
    assign mdr       = mdr_q;
    assign opcode    = get_opcode(ir_q[31:0]);

endmodule

// File: tb/tb_mips_mem_interface.sv
// Self-checking bench for mips_mem_interface: timeline model per access plus literal pins.
module tb_mips_mem_interface;
    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        cpu_rd, cpu_wr, ir_write;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        stall;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] mdr;
    logic        err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    // Model expectations for the current cycle
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_we, exp_err;
    logic [31:0] exp_addr, exp_wd;
    logic [31:0] m_ir, m_mdr;

    mips_mem_interface #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .ir_write  (ir_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .stall     (stall),
        .instr     (instr),
        .opcode    (opcode),
        .mdr       (mdr),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_stall", {31'b0, stall}, {31'b0, exp_stall});
            chk("cyc_req",   {31'b0, mem_req}, {31'b0, exp_req});
            chk("cyc_we",    {31'b0, mem_we}, {31'b0, exp_req && exp_we});
            chk("cyc_err",   {31'b0, err}, {31'b0, exp_err});
            chk("cyc_instr", instr, m_ir);
            chk("cyc_mdr",   mdr, m_mdr);
            chk("cyc_opcode", {26'b0, opcode}, {26'b0, m_ir[31:26]});
            if (exp_req) begin
                chk("cyc_addr",  mem_addr, exp_addr);
                chk("cyc_wdata", mem_wdata, exp_wd);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        cpu_rd = 1'b0; cpu_wr = 1'b0; ir_write = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
    endtask

    // Idle cycles; optional stray ack must be ignored
    task automatic idle(input int n, input logic stray_ack);
        for (int c = 0; c < n; c++) begin
            drive_idle();
            mem_ack   = stray_ack;
            mem_rdata = 32'hFFFF_0000;
            exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0;
            next_cycle();
        end
    endtask

    // Assert reset asynchronously mid-cycle, check zeros, release after one edge
    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        m_ir = 32'h0; m_mdr = 32'h0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0;
        #1;
        chk("rst_req",   {31'b0, mem_req}, 32'h0);
        chk("rst_we",    {31'b0, mem_we}, 32'h0);
        chk("rst_err",   {31'b0, err}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mdr",   mdr, 32'h0);
        chk("rst_addr",  mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        next_cycle();
        rst = 1'b0;
    endtask

    // One access from the request cycle (cycle 0) through DONE.
    // ack_c >= 1: ack in that cycle; ack_c == 0: memory never answers.
    task automatic access(input logic rd, input logic wr, input logic irw,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_c, input logic [31:0] rdata,
                          output int req_cycles);
        int last;
        last = (ack_c > 0) ? ack_c + 1 : TIMEOUT + 30;
        req_cycles = 0;
        for (int c = 0; c <= last; c++) begin
            cpu_rd = rd; cpu_wr = wr; ir_write = irw;
            cpu_addr = addr; cpu_wdata = wd;
            mem_ack   = (c >= 1) && (c == ack_c);
            mem_rdata = (c == ack_c) ? rdata : $urandom;
            if (ack_c > 0) begin
                exp_req   = (c >= 1) && (c <= ack_c);
                exp_stall = (c <= ack_c);
                exp_err   = 1'b0;
                if (c == ack_c + 1 && rd) begin
                    if (irw) m_ir = rdata;
                    else     m_mdr = rdata;
                end
            end else begin
                exp_req   = (c >= 1) && (c <= TIMEOUT);
                exp_stall = 1'b1;
                exp_err   = (c >= TIMEOUT + 1);
            end
            exp_we = wr; exp_addr = addr; exp_wd = wd;
            @(negedge clk);
            if (mem_req) req_cycles++;
            next_cycle();
        end
    endtask

    int nreq;

    initial begin
        drive_idle();
        rst = 1'b1;
        m_ir = 32'h0; m_mdr = 32'h0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0;
        exp_we = 1'b0; exp_addr = 32'h0; exp_wd = 32'h0;
        #1;
        chk("init_req",   {31'b0, mem_req}, 32'h0);
        chk("init_instr", instr, 32'h0);
        chk("init_err",   {31'b0, err}, 32'h0);
        chk("init_addr",  mem_addr, 32'h0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2, 1'b1);

        // Fetch, ack in cycle 1
        access(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1, 32'h8C08_0004, nreq);
        chk("fetch_instr",  instr, 32'h8C08_0004);
        chk("fetch_opcode", {26'b0, opcode}, 32'h23);
        chk("fetch_mdr",    mdr, 32'h0);
        chk("fetch_reqcyc", nreq, 1);
        idle(1, 1'b0);

        // Load with five wait cycles
        access(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 6, 32'hDEAD_BEEF, nreq);
        chk("load_mdr",    mdr, 32'hDEAD_BEEF);
        chk("load_instr",  instr, 32'h8C08_0004);
        chk("load_reqcyc", nreq, 6);
        idle(2, 1'b1);

        // Store, ack in cycle 2; ir_write is meaningless for stores
        access(1'b0, 1'b1, 1'b1, 32'h80, 32'h1234_5678, 2, 32'hCAFE_F00D, nreq);
        chk("store_instr",  instr, 32'h8C08_0004);
        chk("store_mdr",    mdr, 32'hDEAD_BEEF);
        chk("store_reqcyc", nreq, 2);
        idle(1, 1'b0);

        // Back-to-back fetch with a different opcode
        access(1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 3, 32'hAC09_0008, nreq);
        chk("fetch2_opcode", {26'b0, opcode}, 32'h2B);
        idle(1, 1'b0);

        // Timeout: memory never answers; err must outlast a counter wrap period
        access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 0, 32'h0, nreq);
        chk("to_reqcyc", nreq, TIMEOUT);
        chk("to_err",    {31'b0, err}, 32'h1);
        chk("to_stall",  {31'b0, stall}, 32'h1);
        do_reset();
        idle(1, 1'b0);

        // Illegal simultaneous read and write
        cpu_rd = 1'b1; cpu_wr = 1'b1; ir_write = 1'b0;
        cpu_addr = 32'h200; cpu_wdata = 32'h55;
        exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0;
        nreq = 0;
        next_cycle();
        for (int c = 1; c <= 6; c++) begin
            drive_idle();
            mem_ack = (c == 2);
            exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b1;
            @(negedge clk);
            if (mem_req) nreq++;
            next_cycle();
        end
        chk("ill_reqcyc", nreq, 0);
        do_reset();
        idle(1, 1'b0);

        // Put known data in IR/MDR, then reset in cycle 3 of a pending read
        access(1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 1, 32'h0123_4567, nreq);
        access(1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 1, 32'h89AB_CDEF, nreq);
        idle(1, 1'b0);
        for (int c = 0; c <= 2; c++) begin
            cpu_rd = 1'b1; cpu_wr = 1'b0; ir_write = 1'b0;
            cpu_addr = 32'h300; cpu_wdata = 32'h0;
            mem_ack = 1'b0;
            exp_stall = 1'b1; exp_req = (c >= 1); exp_err = 1'b0;
            exp_we = 1'b0; exp_addr = 32'h300; exp_wd = 32'h0;
            next_cycle();
        end
        do_reset();
        // Late ack in cycle 4 must be ignored
        drive_idle();
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0;
        next_cycle();
        drive_idle();
        next_cycle();
        chk("late_instr", instr, 32'h0);
        chk("late_mdr",   mdr, 32'h0);
        chk("late_err",   {31'b0, err}, 32'h0);
        access(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 2, 32'h0000_0020, nreq);
        chk("post_instr", instr, 32'h0000_0020);
        idle(2, 1'b0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
